// File: rtl/strided_convolutional_layer.sv
`default_nettype none
// ============================================================================
// Module   : strided_convolutional_layer
// Purpose  : Streaming strided 2-D convolution with runtime-loadable signed
//            weights and saturating output. Define CONV_RELU_EN to clamp
//            negative results to zero.
// Revision : 1.0
// ============================================================================
module strided_convolutional_layer #(
    parameter int D_WIDTH      = 8,
    parameter int W_WIDTH      = 8,
    parameter int Q_WIDTH      = 16,
    parameter int D_CHANNELS   = 2,
    parameter int Q_CHANNELS   = 3,
    parameter int FILTER_SIZE  = 3,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 32,
    parameter int STRIDE       = 1,
    localparam int c_NW   = Q_CHANNELS * D_CHANNELS * FILTER_SIZE * FILTER_SIZE,
    localparam int c_WA_W = (c_NW > 1) ? $clog2(c_NW) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [D_CHANNELS*D_WIDTH-1:0] input_data,
    input  logic                          weight_we,
    input  logic [c_WA_W-1:0]             weight_addr,
    input  logic [W_WIDTH-1:0]            weight_data,
    output logic [Q_CHANNELS*Q_WIDTH-1:0] output_data,
    output logic                          valid,
    output logic                          frame_done
);

    localparam int c_CW       = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int c_RW       = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int c_PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int c_LB       = (FILTER_SIZE > 1) ? FILTER_SIZE - 1 : 1;
    localparam int c_FM1      = FILTER_SIZE - 1;
    localparam int c_PROD_W   = D_WIDTH + W_WIDTH + 1;
    localparam int c_ACC_W    = c_PROD_W + $clog2(D_CHANNELS * FILTER_SIZE * FILTER_SIZE);
    localparam int c_CMP_W    = (c_ACC_W > Q_WIDTH) ? c_ACC_W : Q_WIDTH;
    localparam int c_LAST_COL = IMAGE_WIDTH - 1 - ((IMAGE_WIDTH - FILTER_SIZE) % STRIDE);
    localparam int c_LAST_ROW = IMAGE_HEIGHT - 1 - ((IMAGE_HEIGHT - FILTER_SIZE) % STRIDE);
    localparam logic signed [c_CMP_W-1:0] c_QMAX =
        $signed({1'b0, {(c_CMP_W-1){1'b1}}} >> (c_CMP_W - Q_WIDTH));
    localparam logic signed [c_CMP_W-1:0] c_QMIN = ~c_QMAX;

    logic [c_CW-1:0] col_q, col_d;
    logic [c_RW-1:0] row_q, row_d;
    logic [c_PW-1:0] cph_q, cph_d, rph_q, rph_d;
    logic [c_PW-1:0] w_cph_inc, w_rph_inc;
    logic            w_emit, w_last;

    logic [D_WIDTH-1:0] w_pix  [D_CHANNELS];
    logic [D_WIDTH-1:0] w_colv [D_CHANNELS][FILTER_SIZE];
    logic [D_WIDTH-1:0] lb_q   [D_CHANNELS][c_LB][IMAGE_WIDTH];
    logic [D_WIDTH-1:0] lb_d   [D_CHANNELS][c_LB][IMAGE_WIDTH];
    logic [D_WIDTH-1:0] win_q  [D_CHANNELS][FILTER_SIZE][FILTER_SIZE];
    logic [D_WIDTH-1:0] win_d  [D_CHANNELS][FILTER_SIZE][FILTER_SIZE];
    logic               emit_q, emit_d, last_q, last_d;

    logic signed [W_WIDTH-1:0] weight_q [c_NW];
    logic signed [W_WIDTH-1:0] weight_d [c_NW];

    logic signed [Q_WIDTH-1:0] w_res [Q_CHANNELS];
    logic signed [Q_WIDTH-1:0] out_q [Q_CHANNELS];
    logic signed [Q_WIDTH-1:0] out_d [Q_CHANNELS];
    logic                      valid_q, valid_d, done_q, done_d;

    // Stride phases are zero at the first complete column/row and advance modulo STRIDE.
    assign w_cph_inc = (32'(cph_q) == STRIDE - 1) ? '0 : cph_q + c_PW'(1);
    assign w_rph_inc = (32'(rph_q) == STRIDE - 1) ? '0 : rph_q + c_PW'(1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        cph_d = cph_q;
        rph_d = rph_q;
        if (clk_en) begin
            if (32'(col_q) == IMAGE_WIDTH - 1) begin
                col_d = '0;
                cph_d = '0;
                if (32'(row_q) == IMAGE_HEIGHT - 1) begin
                    row_d = '0;
                    rph_d = '0;
                end else begin
                    row_d = row_q + c_RW'(1);
                    rph_d = (32'(row_q) + 1 <= c_FM1) ? '0 : w_rph_inc;
                end
            end else begin
                col_d = col_q + c_CW'(1);
                cph_d = (32'(col_q) + 1 <= c_FM1) ? '0 : w_cph_inc;
            end
        end
    end

    assign w_emit = (32'(col_q) >= c_FM1) && (32'(row_q) >= c_FM1) &&
                    (cph_q == '0) && (rph_q == '0);
    assign w_last = (32'(col_q) == c_LAST_COL) && (32'(row_q) == c_LAST_ROW);

    generate
        for (genvar gd = 0; gd < D_CHANNELS; gd++) begin : g_pix
            assign w_pix[gd] = input_data[(D_CHANNELS-1-gd)*D_WIDTH +: D_WIDTH];
        end
    endgenerate

    // Column vector: row 0 is the oldest line, row F-1 is the incoming pixel.
    always_comb begin
        for (int d = 0; d < D_CHANNELS; d++) begin
            w_colv[d][FILTER_SIZE-1] = w_pix[d];
            for (int k = 0; k < FILTER_SIZE - 1; k++) begin
                w_colv[d][FILTER_SIZE-2-k] = lb_q[d][k][col_q];
            end
        end
    end

    always_comb begin
        lb_d = lb_q;
        if (clk_en && !reset && FILTER_SIZE > 1) begin
            for (int d = 0; d < D_CHANNELS; d++) begin
                lb_d[d][0][col_q] = w_pix[d];
                for (int k = 1; k < FILTER_SIZE - 1; k++) begin
                    lb_d[d][k][col_q] = lb_q[d][k-1][col_q];
                end
            end
        end
    end

    always_comb begin
        weight_d = weight_q;
        if (weight_we && 32'(weight_addr) < c_NW) begin
            weight_d[weight_addr] = weight_data;
        end
    end

    always_comb begin
        win_d  = win_q;
        emit_d = emit_q;
        last_d = last_q;
        if (clk_en) begin
            for (int d = 0; d < D_CHANNELS; d++) begin
                for (int fr = 0; fr < FILTER_SIZE; fr++) begin
                    for (int fc = 0; fc < FILTER_SIZE - 1; fc++) begin
                        win_d[d][fr][fc] = win_q[d][fr][fc+1];
                    end
                    win_d[d][fr][FILTER_SIZE-1] = w_colv[d][fr];
                end
            end
            emit_d = w_emit;
            last_d = w_emit & w_last;
        end
    end

    // Full-width signed MAC (pixel zero-extended), then saturate to Q_WIDTH.
    always_comb begin : p_mac
        logic signed [c_PROD_W-1:0] prod;
        logic signed [c_ACC_W-1:0]  acc;
        logic signed [c_CMP_W-1:0]  ext;
        prod  = '0;
        acc   = '0;
        ext   = '0;
        w_res = '{default: '0};
        for (int q = 0; q < Q_CHANNELS; q++) begin
            acc = '0;
            for (int d = 0; d < D_CHANNELS; d++) begin
                for (int fr = 0; fr < FILTER_SIZE; fr++) begin
                    for (int fc = 0; fc < FILTER_SIZE; fc++) begin
                        prod = c_PROD_W'($signed({1'b0, win_q[d][fr][fc]})) *
                               c_PROD_W'(weight_q[((q*D_CHANNELS+d)*FILTER_SIZE+fr)*FILTER_SIZE+fc]);
                        acc  = acc + c_ACC_W'(prod);
                    end
                end
            end
            ext = c_CMP_W'(acc);
            if (ext > c_QMAX) begin
                w_res[q] = c_QMAX[Q_WIDTH-1:0];
            end else if (ext < c_QMIN) begin
                w_res[q] = c_QMIN[Q_WIDTH-1:0];
            end else begin
                w_res[q] = ext[Q_WIDTH-1:0];
            end
`ifdef CONV_RELU_EN
            if (w_res[q][Q_WIDTH-1]) begin
                w_res[q] = '0;
            end
`endif
        end
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        done_d  = done_q;
        if (clk_en) begin
            out_d   = w_res;
            valid_d = emit_q;
            done_d  = last_q;
        end
    end

    // Weights and line buffers survive reset; window validity comes from the counters.
    always_ff @(posedge clk) begin
        weight_q <= weight_d;
        lb_q     <= lb_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            cph_q   <= '0;
            rph_q   <= '0;
            win_q   <= '{default: '0};
            emit_q  <= 1'b0;
            last_q  <= 1'b0;
            out_q   <= '{default: '0};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            cph_q   <= cph_d;
            rph_q   <= rph_d;
            win_q   <= win_d;
            emit_q  <= emit_d;
            last_q  <= last_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    generate
        for (genvar gq = 0; gq < Q_CHANNELS; gq++) begin : g_out
            assign output_data[(Q_CHANNELS-1-gq)*Q_WIDTH +: Q_WIDTH] = out_q[gq];
        end
    endgenerate

    assign valid      = valid_q & clk_en;
    assign frame_done = done_q & valid_q & clk_en;

endmodule
`default_nettype wire

// File: tb/tb_strided_convolutional_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_strided_convolutional_layer
// Purpose  : Scoreboard bench driving a stride-1 and a stride-2 instance with
//            identical 8x6 frames; a negedge monitor checks every result.
// Revision : 1.0
// ============================================================================
module tb_strided_convolutional_layer;

    localparam int DW = 8;
    localparam int WW = 8;
    localparam int QW = 16;
    localparam int DC = 2;
    localparam int QC = 3;
    localparam int F  = 3;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int NW = QC * DC * F * F;

    typedef struct {
        logic [QC*QW-1:0] data;
        logic             last;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             clk_en;
    logic [DC*DW-1:0] input_data;
    logic             weight_we;
    logic [5:0]       weight_addr;
    logic [WW-1:0]    weight_data;
    logic [QC*QW-1:0] out1, out2;
    logic             valid1, valid2, done1, done2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   en_issue = 0;
    int   en_seen  = 0;
    int   pops1    = 0;
    int   pops2    = 0;
    int   mark1    = 0;
    int   mark2    = 0;
    int   tb_col   = 0;
    int   tb_row   = 0;
    int   img [DC][IH][IW];
    int   wt_m [NW];

    strided_convolutional_layer #(
        .D_WIDTH(DW), .W_WIDTH(WW), .Q_WIDTH(QW), .D_CHANNELS(DC), .Q_CHANNELS(QC),
        .FILTER_SIZE(F), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .STRIDE(1)
    ) u_dut_s1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .input_data(input_data),
        .weight_we(weight_we), .weight_addr(weight_addr), .weight_data(weight_data),
        .output_data(out1), .valid(valid1), .frame_done(done1)
    );

    strided_convolutional_layer #(
        .D_WIDTH(DW), .W_WIDTH(WW), .Q_WIDTH(QW), .D_CHANNELS(DC), .Q_CHANNELS(QC),
        .FILTER_SIZE(F), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .STRIDE(2)
    ) u_dut_s2 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .input_data(input_data),
        .weight_we(weight_we), .weight_addr(weight_addr), .weight_data(weight_data),
        .output_data(out2), .valid(valid2), .frame_done(done2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ramp_pix(input int d, input int r, input int c);
        return ((r * IW + c) * 3 + d * 40) & 255;
    endfunction

    function automatic bit emits(input int s, input int c, input int r);
        return (c >= F - 1) && (r >= F - 1) && ((c - (F - 1)) % s == 0) && ((r - (F - 1)) % s == 0);
    endfunction

    // Bottom-right of the final window: (7,5) at stride 1, (6,4) at stride 2.
    function automatic bit is_last(input int s, input int c, input int r);
        return (s == 1) ? (c == 7 && r == 5) : (c == 6 && r == 4);
    endfunction

    function automatic logic [QC*QW-1:0] model(input int c, input int r);
        logic [QC*QW-1:0] res;
        res = '0;
        for (int q = 0; q < QC; q++) begin
            int s;
            s = 0;
            for (int d = 0; d < DC; d++)
                for (int fr = 0; fr < F; fr++)
                    for (int fc = 0; fc < F; fc++)
                        s += img[d][r-F+1+fr][c-F+1+fc] * wt_m[((q*DC+d)*F+fr)*F+fc];
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
            if (s < 0) s = 0;
`endif
            res[(QC-1-q)*QW +: QW] = 16'(s);
        end
        return res;
    endfunction

    task automatic mon_check(input int s, input logic v, input logic fd,
                             input logic [QC*QW-1:0] d, input int cur);
        exp_t e;
        if (fd && !v) begin
            n_err++;
            $display("FAIL frame_done_without_valid_s%0d at enabled cycle %0d", s, cur);
        end
        if (v) begin
            n_vec++;
            if ((s == 1 ? q1.size() : q2.size()) == 0) begin
                n_err++;
                $display("FAIL unexpected_valid_s%0d: got data=%h done=%b at cycle %0d, expected no output",
                         s, d, fd, cur);
            end else begin
                if (s == 1) begin e = q1.pop_front(); pops1++; end
                else        begin e = q2.pop_front(); pops2++; end
                if (d !== e.data || fd !== e.last || cur != e.due) begin
                    n_err++;
                    $display("FAIL output_s%0d: got data=%h done=%b cycle=%0d, expected data=%h done=%b cycle=%0d",
                             s, d, fd, cur, e.data, e.last, e.due);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        int cur;
        if (reset) begin
            n_vec++;
            if (valid1 || valid2 || done1 || done2 || out1 != '0 || out2 != '0) begin
                n_err++;
                $display("FAIL reset_state: got v=%b%b fd=%b%b out=%h/%h, expected all zero",
                         valid1, valid2, done1, done2, out1, out2);
            end
        end
        cur = en_seen;
        if (clk_en) begin
            en_seen++;
        end else begin
            n_vec++;
            if (valid1 || valid2) begin
                n_err++;
                $display("FAIL stall_valid: got valid=%b%b with clk_en=0, expected 00", valid1, valid2);
            end
        end
        mon_check(1, valid1, done1, out1, cur);
        mon_check(2, valid2, done2, out2, cur);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input bit ramp, input int val);
        clk_en = 1'b0;
        for (int a = 0; a < NW; a++) begin
            wt_m[a]     = ramp ? ((a * 7) % 31) - 15 : val;
            weight_we   = 1'b1;
            weight_addr = 6'(a);
            weight_data = 8'(wt_m[a]);
            cycle();
        end
        weight_we = 1'b0;
    endtask

    task automatic reset_pulse(input bit load, input bit ramp, input int val);
        reset  = 1'b1;
        clk_en = 1'b0;
        cycle();
        if (load) load_weights(ramp, val);
        reset  = 1'b0;
        cycle();
        tb_col = 0;
        tb_row = 0;
    endtask

    task automatic push_pixel(input bit ramp, input int pval, input bit use_const,
                              input logic [QW-1:0] cval);
        exp_t e;
        for (int d = 0; d < DC; d++)
            img[d][tb_row][tb_col] = ramp ? ramp_pix(d, tb_row, tb_col) : pval;
        input_data = {8'(img[0][tb_row][tb_col]), 8'(img[1][tb_row][tb_col])};
        clk_en     = 1'b1;
        for (int s = 1; s <= 2; s++) begin
            if (emits(s, tb_col, tb_row)) begin
                e.data = use_const ? {QC{cval}} : model(tb_col, tb_row);
                e.last = is_last(s, tb_col, tb_row);
                e.due  = en_issue + 2;
                if (s == 1) q1.push_back(e);
                else        q2.push_back(e);
            end
        end
        cycle();
        en_issue++;
        clk_en = 1'b0;
        if (tb_col == IW - 1) begin
            tb_col = 0;
            tb_row = (tb_row == IH - 1) ? 0 : tb_row + 1;
        end else begin
            tb_col++;
        end
    endtask

    task automatic run_frame(input bit ramp, input int pval, input bit use_const,
                             input logic [QW-1:0] cval, input int stall_at, input int stop_at);
        for (int i = 0; i < IW * IH; i++) begin
            if (i == stop_at) return;
            if (i == stall_at) begin
                clk_en = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    input_data = 16'($urandom);
                    cycle();
                end
            end
            push_pixel(ramp, pval, use_const, cval);
        end
    endtask

    // Two pixels of a following frame flush the pipeline without completing a window.
    task automatic drain_and_count(input int exp1, input int exp2);
        push_pixel(1'b0, 0, 1'b1, '0);
        push_pixel(1'b0, 0, 1'b1, '0);
        n_vec++;
        if (pops1 - mark1 != exp1 || pops2 - mark2 != exp2 || q1.size() != 0 || q2.size() != 0) begin
            n_err++;
            $display("FAIL output_count: got s1=%0d s2=%0d pending=%0d/%0d, expected s1=%0d s2=%0d pending=0/0",
                     pops1 - mark1, pops2 - mark2, q1.size(), q2.size(), exp1, exp2);
        end
        mark1 = pops1;
        mark2 = pops2;
    endtask

    initial begin
        reset       = 1'b1;
        clk_en      = 1'b0;
        input_data  = '0;
        weight_we   = 1'b0;
        weight_addr = '0;
        weight_data = '0;
        cycle();

        for (int i = 0; i < 4; i++) begin
            clk_en     = 1'b1;
            input_data = 16'($urandom);
            cycle();
            en_issue++;
        end
        clk_en = 1'b0;
        load_weights(1'b0, 1);
        reset = 1'b0;
        cycle();
        tb_col = 0;
        tb_row = 0;

        run_frame(1'b0, 1, 1'b1, 16'h0012, -1, -1);
        run_frame(1'b0, 1, 1'b1, 16'h0012, -1, -1);
        drain_and_count(48, 12);

        reset_pulse(1'b1, 1'b0, 127);
        run_frame(1'b0, 255, 1'b1, 16'h7FFF, -1, -1);
        drain_and_count(24, 6);

        reset_pulse(1'b1, 1'b0, -128);
`ifdef CONV_RELU_EN
        run_frame(1'b0, 255, 1'b1, 16'h0000, -1, -1);
`else
        run_frame(1'b0, 255, 1'b1, 16'h8000, -1, -1);
`endif
        drain_and_count(24, 6);

        reset_pulse(1'b1, 1'b1, 0);
        run_frame(1'b1, 0, 1'b0, '0, -1, -1);
        run_frame(1'b1, 0, 1'b0, '0, 20, -1);
        drain_and_count(48, 12);

        reset_pulse(1'b0, 1'b0, 0);
        run_frame(1'b1, 0, 1'b0, '0, -1, 20);
        reset  = 1'b1;
        clk_en = 1'b0;
        q1.delete();
        q2.delete();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        tb_col = 0;
        tb_row = 0;
        mark1  = pops1;
        mark2  = pops2;
        run_frame(1'b1, 0, 1'b0, '0, -1, -1);
        drain_and_count(24, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
